// File: rtl/time_keeper_pkg.sv
// Shared mode encodings and calendar constants for the digital clock blocks.
// Mirrors the TIME-mode constants of the shared clock definitions.
package time_keeper_pkg;

    localparam logic [1:0] M1_TIME  = 2'd0;
    localparam logic [1:0] M1_DATE  = 2'd1;
    localparam logic [1:0] M1_TIMER = 2'd2;
    localparam logic [1:0] M1_ALARM = 2'd3;

    localparam logic [1:0] M2_TIME_G    = 2'd0;
    localparam logic [1:0] M2_TIME_HOUR = 2'd1;
    localparam logic [1:0] M2_TIME_MIN  = 2'd2;
    localparam logic [1:0] M2_TIME_SEC  = 2'd3;

    localparam int HOURS_PER_DAY = 24;
    localparam int MINS_PER_HOUR = 60;

    // Set modes are the TIME sub-modes that pick a field to edit.
    function automatic logic is_set_mode(input logic [1:0] m1, input logic [1:0] m2);
        return (m1 == M1_TIME) && (m2 != M2_TIME_G);
    endfunction

endpackage

// File: rtl/time_keeper_sec_tick_gen.sv
// Once-per-second enable: a divider cleared while run is low that pulses
// tick on its terminal count.
module sec_tick_gen #(
    parameter int CLOCKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(CLOCKS_PER_SEC);
    localparam logic [W-1:0] TERM = W'(CLOCKS_PER_SEC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || cnt_q == TERM) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = run && (cnt_q == TERM);

endmodule

// File: rtl/time_keeper.sv
// 24-hour time-of-day counter with button-driven field setting and
// registered second/day pulses for downstream alarm and date blocks.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLOCKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode1,
    input  logic [1:0] mode2,
    input  logic       increase,
    output logic [4:0] hours,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic       sec_tick,
    output logic       day_tick
);

    localparam logic [4:0] HOUR_MAX = 5'(HOURS_PER_DAY - 1);
    localparam logic [5:0] MIN_MAX  = 6'(MINS_PER_HOUR - 1);

    logic [4:0] hours_q, hours_d;
    logic [5:0] mins_q, mins_d;
    logic [5:0] secs_q, secs_d;
    logic       sec_tick_q, sec_tick_d;
    logic       day_tick_q, day_tick_d;
    logic       inc_q;
    logic       set_mode, inc_rise, tick;

    assign set_mode = is_set_mode(mode1, mode2);
    assign inc_rise = increase & ~inc_q;

    sec_tick_gen #(.CLOCKS_PER_SEC(CLOCKS_PER_SEC)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (!set_mode),
        .tick  (tick)
    );

    // ">= MAX" rather than "== MAX" also scrubs any out-of-range value to 0.
    always_comb begin
        hours_d    = hours_q;
        mins_d     = mins_q;
        secs_d     = secs_q;
        sec_tick_d = tick;
        day_tick_d = 1'b0;
        if (tick) begin
            secs_d = secs_q + 1'b1;
            if (secs_q >= MIN_MAX) begin
                secs_d = '0;
                mins_d = mins_q + 1'b1;
                if (mins_q >= MIN_MAX) begin
                    mins_d  = '0;
                    hours_d = hours_q + 1'b1;
                    if (hours_q >= HOUR_MAX) begin
                        hours_d    = '0;
                        day_tick_d = 1'b1;
                    end
                end
            end
        end else if (set_mode && inc_rise) begin
            case (mode2)
                M2_TIME_HOUR: hours_d = (hours_q >= HOUR_MAX) ? '0 : hours_q + 1'b1;
                M2_TIME_MIN:  mins_d  = (mins_q  >= MIN_MAX)  ? '0 : mins_q + 1'b1;
                M2_TIME_SEC:  secs_d  = (secs_q  >= MIN_MAX)  ? '0 : secs_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours_q    <= '0;
            mins_q     <= '0;
            secs_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            inc_q      <= 1'b0;
        end else begin
            hours_q    <= hours_d;
            mins_q     <= mins_d;
            secs_q     <= secs_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            inc_q      <= increase;
        end
    end

    assign hours    = hours_q;
    assign mins     = mins_q;
    assign secs     = secs_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 4-clock second.
module tb_time_keeper;
    import time_keeper_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] mode1 = M1_TIME;
    logic [1:0] mode2 = M2_TIME_G;
    logic       increase = 1'b0;
    logic [4:0] hours;
    logic [5:0] mins, secs;
    logic       sec_tick, day_tick;

    int checks = 0;
    int fails  = 0;
    int st_cnt = 0;
    int dt_cnt = 0;

    time_keeper #(.CLOCKS_PER_SEC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode1    (mode1),
        .mode2    (mode2),
        .increase (increase),
        .hours    (hours),
        .mins     (mins),
        .secs     (secs),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling pulses at each negedge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            st_cnt += int'(sec_tick);
            dt_cnt += int'(day_tick);
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            increase = 1'b1;
            cycles(1);
            increase = 1'b0;
            cycles(1);
        end
    endtask

    initial begin
        // 1: reset asserted mid-cycle, released on a negedge
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_hours", 32'(hours), 0);
        chk("rst_mins", 32'(mins), 0);
        chk("rst_secs", 32'(secs), 0);
        chk("rst_sec_tick", 32'(sec_tick), 0);
        chk("rst_day_tick", 32'(day_tick), 0);
        st_cnt = 0;
        cycles(4);
        chk("first_sec", 32'(secs), 1);
        chk("first_sec_tick_cnt", 32'(st_cnt), 1);

        // 2: hour set, wraps 23 -> 0
        mode2 = M2_TIME_HOUR;
        st_cnt = 0;
        for (int i = 1; i <= 26; i++) begin
            increase = 1'b1;
            cycles(1);
            chk($sformatf("hour_step_%0d", i), 32'(hours), 32'(i % 24));
            increase = 1'b0;
            cycles(1);
        end
        chk("hour_mins_kept", 32'(mins), 0);
        chk("hour_secs_kept", 32'(secs), 1);
        chk("hour_no_sec_tick", 32'(st_cnt), 0);

        // 3: minute set without carry, then a held button
        mode2 = M2_TIME_MIN;
        pulses(70);
        chk("min_after_70", 32'(mins), 10);
        chk("min_hours_kept", 32'(hours), 2);
        increase = 1'b1;
        cycles(10);
        increase = 1'b0;
        cycles(1);
        chk("min_held_once", 32'(mins), 11);

        // 4: set 23:59:50 and run through midnight
        mode2 = M2_TIME_HOUR;
        pulses(21);
        mode2 = M2_TIME_MIN;
        pulses(48);
        mode2 = M2_TIME_SEC;
        pulses(49);
        chk("preset_hours", 32'(hours), 23);
        chk("preset_mins", 32'(mins), 59);
        chk("preset_secs", 32'(secs), 50);
        chk("sec_no_carry_tick", 32'(st_cnt), 0);
        mode2 = M2_TIME_G;
        st_cnt = 0;
        dt_cnt = 0;
        cycles(39);
        chk("pre_mid_secs", 32'(secs), 59);
        chk("pre_mid_day_tick", 32'(dt_cnt), 0);
        cycles(1);
        chk("mid_hours", 32'(hours), 0);
        chk("mid_mins", 32'(mins), 0);
        chk("mid_secs", 32'(secs), 0);
        chk("mid_day_tick_now", 32'(day_tick), 1);
        chk("mid_sec_ticks", 32'(st_cnt), 10);
        cycles(100);
        chk("day_tick_once", 32'(dt_cnt), 1);
        chk("post_mid_secs", 32'(secs), 25);

        // 5: set 02:10 then async reset between edges
        mode2 = M2_TIME_HOUR;
        pulses(2);
        mode2 = M2_TIME_MIN;
        pulses(10);
        mode2 = M2_TIME_G;
        cycles(6);
        chk("pre_rst_hours", 32'(hours), 2);
        chk("pre_rst_mins", 32'(mins), 10);
        @(posedge clk);
        #5 reset = 1'b1;
        #1;
        chk("async_hours", 32'(hours), 0);
        chk("async_mins", 32'(mins), 0);
        chk("async_secs", 32'(secs), 0);
        cycles(3);
        chk("held_rst_secs", 32'(secs), 0);
        chk("held_rst_mins", 32'(mins), 0);

        // 6: increase ignored outside TIME set modes
        reset = 1'b0;
        mode1 = M1_ALARM;
        mode2 = M2_TIME_HOUR;
        repeat (5) begin
            increase = 1'b1;
            cycles(1);
            increase = 1'b0;
            cycles(3);
        end
        chk("run_hours", 32'(hours), 0);
        chk("run_mins", 32'(mins), 0);
        chk("run_secs", 32'(secs), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Time-of-day counter for the digital clock; it is the producer of the hours/mins buses that the alarm block compares against.
- Derives a once-per-second enable from clk and counts seconds, minutes and hours in 24-hour format.
- Lets the user set hour/min/sec with the increase button in TIME setting modes.
- Emits a one-clock day_tick pulse at midnight rollover for the date counter.

Parameters:
CLOCKS_PER_SEC, 100, number of clk cycles per second; legal range 2 to 2^24.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous reset, active-high
mode1  input  2  major mode (TIME/DATE/TIMER/ALARM encodings from shared constants)
mode2  input  2  minor mode within the major mode
increase  input  1  set button; one step per rising edge of the level
hours  output  5  current hour, 0..23
mins  output  6  current minute, 0..59
secs  output  6  current second, 0..59
sec_tick  output  1  one-clock pulse when a second elapses, only while time is advancing
day_tick  output  1  one-clock pulse on 23:59:59 -> 00:00:00

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset state: hours=0, mins=0, secs=0, sec_tick=0, day_tick=0, divider=0, increase edge register=0. Outputs go to 0 immediately on reset assertion, without waiting for a clk edge. Reset may be released at any clk phase; counting restarts from divider=0.
- Set modes: mode1=M1_TIME with mode2 in {M2_TIME_HOUR, M2_TIME_MIN, M2_TIME_SEC}.
- Run mode: every other mode1/mode2 combination, including all non-TIME major modes.
- Run mode, divider: the divider counts 0..CLOCKS_PER_SEC-1. At the terminal count, sec_tick=1 for that cycle and the time advances at the same clk edge.
- Run mode, advance rules:
  - secs 59->0 carries into mins.
  - mins 59->0 carries into hours.
  - hours 23->0 asserts day_tick for exactly one clock, coincident with the registered 00:00:00.
- Run mode, increase: ignored.
- Set modes, timekeeping: the divider is held at 0, and sec_tick and day_tick stay 0.
- Set modes, edge detection: inc_q is increase registered. A step is inc_rise = increase & ~inc_q.
- Set modes, step latency: on a step, the selected field increments by 1 at that same clk edge. The new value is visible after that edge, giving a latency of 1 clk from the sampled rise.
- Set modes, field increments:
  - HOUR: 23->0, no other field affected.
  - MIN: 59->0, no carry.
  - SEC: 59->0, no carry.
- Held increase: increase held high for N cycles gives exactly one step. A new step needs increase to return to 0 for at least one clk sample.
- Leaving a set mode: the divider restarts at 0, so the first sec_tick comes CLOCKS_PER_SEC clocks after the mode change.
- Mode switch mid-step: if mode2 changes in the same cycle as inc_rise, the new mode2 value selects the field. If the new mode is a run mode, the step is ignored.
- Out-of-range values (hours >23, mins/secs >59) are unreachable. Defensively, any such value is forced to 0 on the next advance or step.
- Arithmetic: unsigned, fixed widths. The divider width is ceil(log2(CLOCKS_PER_SEC)), computed with $clog2.
- Outputs are registers only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared constants file (dclockshare.v):
  - Already holds M1_TIME, M2_TIME_G and the other mode encodings.
  - M2_TIME_HOUR, M2_TIME_MIN and M2_TIME_SEC are defined there alongside the existing TIME constants.
  - HOURS_PER_DAY=24 and MINS_PER_HOUR=60 are added there as well.
- Sub-module sec_tick_gen:
  - Parameters: CLOCKS_PER_SEC.
  - Ports: clk, reset, run, tick.
  - A counter that is cleared while run=0 and pulses tick at the terminal count.
- time_keeper instantiates sec_tick_gen and holds the h/m/s registers and the increase edge detector.

Test Plan:
1. Reset: bench uses CLOCKS_PER_SEC=4. Assert reset mid-cycle for 3 clocks, release at the negedge in mode M1_TIME/M2_TIME_G -> 00:00:00, day_tick=0. After 4 posedges, secs=1 and sec_tick was seen exactly once.
2. Hour set: enter M2_TIME_HOUR and apply 26 one-clock increase pulses spaced 2 clocks apart -> after each pulse hours is 1..23, 0, 1, 2. mins and secs are unchanged and sec_tick never fires.
3. Minute set:
   - In M2_TIME_MIN, apply 70 pulses -> mins ends at 10 and hours stays 2.
   - Hold increase high for 10 clocks -> mins becomes 11 (a single step).
4. Midnight rollover: set 23:59:50 and switch to M2_TIME_G. After 40 clocks (10 ticks) -> 00:00:00, day_tick high for exactly 1 clock, and no further day_tick within the next 100 clocks.
5. Async reset mid-count: run to 02:10:xx, then assert reset midway between posedges -> hours/mins/secs read 0 before the next posedge and stay 0 while reset is held.
6. Ignore in run mode: set mode1=M1_ALARM and pulse increase 5 times -> hours/mins/secs advance only by ticks (secs increases by 1 per 4 clocks); set fields are unchanged.
